// File: rtl/spi_sram_responder_if.sv
// Serial memory bus between the SPI master (CPU or bench) and the SRAM responder,
// bundled with the parallel preload port and the busy flag.
interface spi_sram_responder_if #(
    parameter int ADDR_W = 8
) ();
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [7:0]        ld_data;
    logic              busy;

    modport master (
        output cs_n, mosi, ld_en, ld_addr, ld_data,
        input  miso, miso_oe, busy
    );

    modport slave (
        input  cs_n, mosi, ld_en, ld_addr, ld_data,
        output miso, miso_oe, busy
    );
endinterface

// File: rtl/spi_sram_responder.sv
// SPI-slave byte memory: READ/WRITE opcodes with a 16-bit address and auto-increment,
// SCLK == clk, plus a parallel preload port.
module spi_sram_responder #(
    parameter int          ADDR_W = 8,
    parameter logic [7:0]  CMD_RD = 8'h03,
    parameter logic [7:0]  CMD_WR = 8'h02
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_sram_responder_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WRITE, READ, IGNORE} state_t;

    state_t            state, state_next;
    logic [3:0]        bit_cnt, bit_cnt_next;
    logic [ADDR_W-1:0] addr, addr_next;
    logic [7:0]        rx_shift, rx_next;
    logic [7:0]        tx_shift, tx_next;
    logic              miso_q, miso_next;
    logic              oe_q, oe_next;
    logic              is_read, is_read_next;
    logic              armed, armed_next;
    logic              spi_we;
    logic [7:0]        mem [DEPTH];

    logic [7:0]        rx_in;
    logic [ADDR_W-1:0] addr_in;
    logic [ADDR_W-1:0] addr_inc;

    // Shifting into an ADDR_W-wide register drops wire address bits above ADDR_W.
    assign rx_in    = {rx_shift[6:0], bus.mosi};
    assign addr_in  = ADDR_W'({addr, bus.mosi});
    assign addr_inc = addr + ADDR_W'(1);

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        addr_next    = addr;
        rx_next      = rx_shift;
        tx_next      = tx_shift;
        miso_next    = miso_q;
        oe_next      = oe_q;
        is_read_next = is_read;
        armed_next   = armed;
        spi_we       = 1'b0;

        if (bus.cs_n) begin
            state_next   = IDLE;
            bit_cnt_next = 4'd0;
            miso_next    = 1'b0;
            oe_next      = 1'b0;
            armed_next   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    // Not armed means a reset hit mid-frame; wait for a deselect first.
                    if (armed) begin
                        state_next   = CMD;
                        rx_next      = rx_in;
                        bit_cnt_next = 4'd1;
                    end
                end
                CMD: begin
                    rx_next = rx_in;
                    if (bit_cnt == 4'd7) begin
                        bit_cnt_next = 4'd0;
                        if (rx_in == CMD_RD) begin
                            state_next   = ADDR;
                            is_read_next = 1'b1;
                        end else if (rx_in == CMD_WR) begin
                            state_next   = ADDR;
                            is_read_next = 1'b0;
                        end else begin
                            state_next = IGNORE;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt + 4'd1;
                    end
                end
                ADDR: begin
                    addr_next = addr_in;
                    if (bit_cnt == 4'd15) begin
                        bit_cnt_next = 4'd0;
                        if (is_read) begin
                            tx_next    = mem[addr_in];
                            miso_next  = mem[addr_in][7];
                            oe_next    = 1'b1;
                            state_next = READ;
                        end else begin
                            state_next = WRITE;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt + 4'd1;
                    end
                end
                WRITE: begin
                    rx_next = rx_in;
                    if (bit_cnt == 4'd7) begin
                        spi_we       = 1'b1;
                        addr_next    = addr_inc;
                        bit_cnt_next = 4'd0;
                    end else begin
                        bit_cnt_next = bit_cnt + 4'd1;
                    end
                end
                READ: begin
                    // Fetch the next byte on the edge that would shift past bit 0: no idle bit.
                    if (bit_cnt == 4'd7) begin
                        addr_next    = addr_inc;
                        tx_next      = mem[addr_inc];
                        miso_next    = mem[addr_inc][7];
                        bit_cnt_next = 4'd0;
                    end else begin
                        tx_next      = {tx_shift[6:0], 1'b0};
                        miso_next    = tx_shift[6];
                        bit_cnt_next = bit_cnt + 4'd1;
                    end
                end
                IGNORE: begin
                    miso_next = 1'b0;
                    oe_next   = 1'b0;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= 4'd0;
            addr     <= '0;
            rx_shift <= 8'd0;
            tx_shift <= 8'd0;
            miso_q   <= 1'b0;
            oe_q     <= 1'b0;
            is_read  <= 1'b0;
            armed    <= 1'b0;
        end else begin
            state    <= state_next;
            bit_cnt  <= bit_cnt_next;
            addr     <= addr_next;
            rx_shift <= rx_next;
            tx_shift <= tx_next;
            miso_q   <= miso_next;
            oe_q     <= oe_next;
            is_read  <= is_read_next;
            armed    <= armed_next;
        end
    end

    // Contents survive reset; the SPI commit is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (bus.ld_en)
            mem[bus.ld_addr] <= bus.ld_data;
        if (spi_we && rst_n)
            mem[addr] <= rx_in;
    end

    assign bus.miso    = miso_q;
    assign bus.miso_oe = oe_q;
    assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_spi_sram_responder.sv
// Self-checking bench: directed SPI frames plus random traffic scored against
// a byte-array model of the memory.
module tb_spi_sram_responder;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_sram_responder_if #(.ADDR_W(ADDR_W)) bus ();

    spi_sram_responder #(
        .ADDR_W (ADDR_W),
        .CMD_RD (8'h03),
        .CMD_WR (8'h02)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [7:0] model_mem [DEPTH];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One SCLK period: drive, let the rising edge sample, return at the falling edge.
    task automatic applyStimulus(input logic cs, input logic bit_in);
        bus.cs_n = cs;
        bus.mosi = bit_in;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sendByte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) applyStimulus(1'b0, b[i]);
    endtask

    function automatic int wrapAddr(input logic [15:0] a, input int i);
        return (int'(a) + i) % DEPTH;
    endfunction

    task automatic loadByte(input logic [7:0] a, input logic [7:0] d);
        bus.ld_en   = 1'b1;
        bus.ld_addr = a;
        bus.ld_data = d;
        applyStimulus(1'b1, 1'b0);
        bus.ld_en   = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic spiWrite(input logic [15:0] a, input int n, input logic [31:0] data);
        logic [7:0] d;
        sendByte(8'h02);
        checkOutput("wr_busy", {31'd0, bus.busy}, 32'd1);
        sendByte(a[15:8]);
        sendByte(a[7:0]);
        for (int i = 0; i < n; i++) begin
            d = data[8*i +: 8];
            sendByte(d);
            model_mem[wrapAddr(a, i)] = d;
        end
        applyStimulus(1'b1, 1'b0);
        checkOutput("wr_end_busy", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic spiRead(input logic [15:0] a, input int n);
        logic [7:0] e;
        sendByte(8'h03);
        sendByte(a[15:8]);
        checkOutput("rd_addr_oe", {31'd0, bus.miso_oe}, 32'd0);
        sendByte(a[7:0]);
        for (int i = 0; i < n; i++) begin
            e = model_mem[wrapAddr(a, i)];
            for (int b = 7; b >= 0; b--) begin
                checkOutput("rd_oe_miso", {30'd0, bus.miso_oe, bus.miso}, {30'd0, 1'b1, e[b]});
                applyStimulus(1'b0, 1'($urandom_range(0, 1)));
            end
        end
        applyStimulus(1'b1, 1'b0);
        checkOutput("rd_end", {29'd0, bus.busy, bus.miso_oe, bus.miso}, 32'd0);
    endtask

    task automatic junkTxn(input logic [7:0] cmd, input logic [15:0] a, input logic [7:0] d);
        logic [31:0] frame;
        frame = {cmd, a, d};
        for (int i = 31; i >= 0; i--) begin
            applyStimulus(1'b0, frame[i]);
            checkOutput("junk_state", {29'd0, bus.busy, bus.miso_oe, bus.miso}, 32'd4);
        end
        applyStimulus(1'b1, 1'b0);
        checkOutput("junk_end_busy", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        logic [7:0]  c;
        logic [15:0] ra;
        logic [31:0] rd;
        int          op;
        int          len;

        bus.cs_n    = 1'b1;
        bus.mosi    = 1'b0;
        bus.ld_en   = 1'b0;
        bus.ld_addr = '0;
        bus.ld_data = 8'd0;

        rst_n = 1'b0;
        repeat (2) applyStimulus(1'b1, 1'b0);
        checkOutput("reset_outputs", {29'd0, bus.busy, bus.miso_oe, bus.miso}, 32'd0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0);

        for (int i = 0; i < DEPTH; i++) loadByte(8'(i), 8'($urandom));

        $display("[TB] write/read A5 at 0x0012");
        spiWrite(16'h0012, 1, 32'h000000A5);
        spiRead(16'h0012, 1);

        $display("[TB] sequential wrap at 0x00FE");
        spiWrite(16'h00FE, 3, 32'h00332211);
        spiRead(16'h00FE, 3);

        $display("[TB] unknown command 0x05");
        junkTxn(8'h05, 16'h0000, 8'hFF);
        spiRead(16'h0000, 1);

        $display("[TB] aborted write at 0x0040");
        sendByte(8'h02);
        sendByte(8'h00);
        sendByte(8'h40);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("abort_busy", {31'd0, bus.busy}, 32'd0);
        spiRead(16'h0040, 1);

        $display("[TB] reset during read");
        sendByte(8'h03);
        sendByte(8'h00);
        sendByte(8'h12);
        for (int b = 7; b > 4; b--) begin
            checkOutput("pre_reset_miso", {31'd0, bus.miso}, {31'd0, model_mem[8'h12][b]});
            applyStimulus(1'b0, 1'b0);
        end
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0);
        rst_n = 1'b1;
        checkOutput("mid_reset_out", {29'd0, bus.busy, bus.miso_oe, bus.miso}, 32'd0);
        rd = 32'h00030012;
        for (int i = 23; i >= 0; i--) begin
            applyStimulus(1'b0, rd[i]);
            checkOutput("post_reset_ignore", {29'd0, bus.busy, bus.miso_oe, bus.miso}, 32'd0);
        end
        applyStimulus(1'b1, 1'b0);
        spiRead(16'h0012, 2);

        $display("[TB] load port and collision at 0x34");
        loadByte(8'h34, 8'h5A);
        spiRead(16'h1234, 1);
        sendByte(8'h02);
        sendByte(8'h00);
        sendByte(8'h34);
        c = 8'hC3;
        for (int b = 7; b > 0; b--) applyStimulus(1'b0, c[b]);
        bus.ld_en   = 1'b1;
        bus.ld_addr = 8'h34;
        bus.ld_data = 8'h99;
        applyStimulus(1'b0, c[0]);
        bus.ld_en   = 1'b0;
        model_mem[8'h34] = 8'hC3;
        applyStimulus(1'b1, 1'b0);
        spiRead(16'hAB34, 1);

        $display("[TB] random traffic");
        for (int t = 0; t < 40; t++) begin
            op  = int'($urandom_range(0, 3));
            ra  = 16'($urandom);
            len = int'($urandom_range(1, 4));
            rd  = $urandom;
            case (op)
                0: spiWrite(ra, len, rd);
                1: spiRead(ra, len);
                2: begin
                    c = 8'($urandom);
                    if (c == 8'h02 || c == 8'h03) c = 8'hA7;
                    junkTxn(c, ra, rd[7:0]);
                end
                default: for (int i = 0; i < len; i++) loadByte(8'(int'(ra) + i), rd[8*i +: 8]);
            endcase
            repeat (int'($urandom_range(0, 2))) applyStimulus(1'b1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
